// File: rtl/mem_master.sv
// mem_master: load/store master onto a byte-enabled memory with async reads.
// Misaligned accesses are broken into single-byte memory cycles.
module mem_master #(
    parameter int NKB = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_fault,
    output logic [63:0] mem_addr,
    output logic [2:0]  mem_widthsel,
    output logic [63:0] mem_writedata,
    output logic        mem_we,
    input  logic [63:0] mem_readdata
);

    localparam logic [64:0] LAST = 65'(NKB * 1024 - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [63:0] addr_q;
    logic [63:0] wdata_q;
    logic [63:0] data_q;
    logic [63:0] rdata_q;
    logic        fault_q;
    logic [2:0]  k;

    logic [3:0]  req_n;
    logic [64:0] req_end;
    logic        req_fault;
    logic        req_aligned;
    logic [63:0] raw;
    logic        split_last;

    // Byte-count-minus-one; doubles as the byte-enable encoding.
    function automatic logic [2:0] size_mask(input logic [1:0] sz);
        logic [2:0] m;
        unique case (sz)
            2'b00:   m = 3'b000;
            2'b01:   m = 3'b001;
            2'b10:   m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

    function automatic logic [63:0] extend(
        input logic [63:0] d,
        input logic [1:0]  sz,
        input logic        sg
    );
        logic [63:0] r;
        unique case (sz)
            2'b00:   r = {{56{sg & d[7]}}, d[7:0]};
            2'b01:   r = {{48{sg & d[15]}}, d[15:0]};
            2'b10:   r = {{32{sg & d[31]}}, d[31:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // 65-bit end address so accesses near 2^64 cannot wrap into range.
    assign req_n       = 4'd1 << req_size;
    assign req_end     = {1'b0, req_addr} + 65'(req_n) - 65'd1;
    assign req_fault   = req_end > LAST;
    assign req_aligned = (req_addr[2:0] & size_mask(req_size)) == 3'b000;
    assign split_last  = k == size_mask(size_q);

    assign resp_valid = state == RESP;
    assign resp_rdata = resp_valid ? rdata_q : 64'd0;
    assign resp_fault = resp_valid & fault_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        req_ready     = 1'b0;
        mem_addr      = 64'd0;
        mem_widthsel  = 3'b000;
        mem_writedata = 64'd0;
        mem_we        = 1'b0;
        raw           = data_q;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_fault) begin
                        state_nx = RESP;
                    end else if (req_aligned) begin
                        state_nx = ACCESS;
                    end else begin
                        state_nx = SPLIT;
                    end
                end
            end
            ACCESS: begin
                mem_addr      = addr_q;
                mem_widthsel  = size_mask(size_q);
                mem_writedata = wdata_q;
                mem_we        = we_q;
                raw           = mem_readdata;
                state_nx      = RESP;
            end
            SPLIT: begin
                mem_addr      = addr_q + {61'd0, k};
                mem_writedata = {56'd0, wdata_q[{k, 3'b000} +: 8]};
                mem_we        = we_q;
                raw[{k, 3'b000} +: 8] = mem_readdata[7:0];
                if (split_last) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            we_q     <= 1'b0;
            signed_q <= 1'b0;
            size_q   <= 2'b00;
            addr_q   <= 64'd0;
            wdata_q  <= 64'd0;
            data_q   <= 64'd0;
            rdata_q  <= 64'd0;
            fault_q  <= 1'b0;
            k        <= 3'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        signed_q <= req_signed;
                        size_q   <= req_size;
                        addr_q   <= req_addr;
                        wdata_q  <= req_wdata;
                        data_q   <= 64'd0;
                        rdata_q  <= 64'd0;
                        fault_q  <= req_fault;
                        k        <= 3'd0;
                    end
                end
                ACCESS: begin
                    rdata_q <= we_q ? 64'd0 : extend(raw, size_q, signed_q);
                end
                SPLIT: begin
                    data_q <= raw;
                    k      <= k + 3'd1;
                    if (split_last) begin
                        rdata_q <= we_q ? 64'd0 : extend(raw, size_q, signed_q);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed transactions against a transaction-level model,
// with a per-cycle compare of handshake, response and memory-port outputs.
`timescale 1ns/1ps
module tb_mem_master;

    localparam int NKB = 2;
    localparam int MSZ = NKB * 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        preload;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_fault;
    logic [63:0] mem_addr;
    logic [2:0]  mem_widthsel;
    logic [63:0] mem_writedata;
    logic        mem_we;
    logic [63:0] mem_readdata;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0] mem [MSZ];
    logic [7:0] ref_mem [MSZ];

    // transaction model of the request in flight
    logic        in_txn = 1'b0;
    int          t_acc;
    int          m_lat;
    int          m_n;
    logic        m_fault;
    logic        m_al;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wd;
    logic [63:0] m_rdata;

    int          cj;
    logic        e_we;
    logic [2:0]  e_ws;
    logic [63:0] e_addr;
    logic [63:0] e_wd;

    mem_master #(.NKB(NKB)) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we(req_we),
        .req_size(req_size),
        .req_signed(req_signed),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_fault(resp_fault),
        .mem_addr(mem_addr),
        .mem_widthsel(mem_widthsel),
        .mem_writedata(mem_writedata),
        .mem_we(mem_we),
        .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nbytes(input logic [2:0] ws);
        return ws[2] ? 8 : ws[1] ? 4 : ws[0] ? 2 : 1;
    endfunction

    function automatic logic [2:0] wsel(input int n);
        return n == 8 ? 3'b111 : n == 4 ? 3'b011 : n == 2 ? 3'b001 : 3'b000;
    endfunction

    always_comb begin
        mem_readdata = 64'd0;
        for (int b = 0; b < 8; b++) begin
            if (b < nbytes(mem_widthsel)) begin
                mem_readdata[8*b +: 8] =
                    mem[int'((mem_addr + 64'(b)) % 64'(MSZ))];
            end
        end
    end

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < MSZ; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (mem_we) begin
            for (int b = 0; b < 8; b++) begin
                if (b < nbytes(mem_widthsel)) begin
                    mem[int'((mem_addr + 64'(b)) % 64'(MSZ))] <=
                        mem_writedata[8*b +: 8];
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // per-cycle compare against the model
    always @(negedge clk) begin
        if (!reset) begin
            if (in_txn) begin
                cj = cyc - t_acc;
                e_we = 1'b0;
                e_ws = 3'b000;
                e_addr = 64'd0;
                e_wd = 64'd0;
                if (!m_fault && m_al && cj == 1) begin
                    e_we = m_we;
                    e_ws = wsel(m_n);
                    e_addr = m_addr;
                    e_wd = m_wd;
                end else if (!m_fault && !m_al && cj >= 1 && cj <= m_n) begin
                    e_we = m_we;
                    e_addr = m_addr + 64'(cj - 1);
                    e_wd = (m_wd >> (8 * (cj - 1))) & 64'hFF;
                end
                chk("req_ready_busy", 64'(req_ready), 64'd0);
                chk("resp_valid", 64'(resp_valid), 64'(cj >= m_lat));
                if (resp_valid) begin
                    chk("resp_rdata", resp_rdata, m_rdata);
                    chk("resp_fault", 64'(resp_fault), 64'(m_fault));
                end
                chk("mem_we", 64'(mem_we), 64'(e_we));
                chk("mem_addr", mem_addr, e_addr);
                chk("mem_widthsel", 64'(mem_widthsel), 64'(e_ws));
                chk("mem_writedata", mem_writedata, e_wd);
            end else begin
                chk("req_ready_idle", 64'(req_ready), 64'd1);
                chk("resp_valid_idle", 64'(resp_valid), 64'd0);
                chk("mem_we_idle", 64'(mem_we), 64'd0);
                chk("mem_addr_idle", mem_addr, 64'd0);
            end
        end
    end

    task automatic check_image(input string nm);
        int bad;
        int first;
        bad = 0;
        first = -1;
        for (int i = 0; i < MSZ; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL image_%s actual=%0d bad bytes (first at %h) required=0",
                     nm, bad, first);
        end
    endtask

    task automatic set_model(input logic we, input logic [1:0] sz,
                             input logic sg, input logic [63:0] a,
                             input logic [63:0] wd);
        int n;
        logic [64:0] endp;
        logic [63:0] d;
        n = 1 << sz;
        endp = {1'b0, a} + 65'(n) - 65'd1;
        m_fault = endp > 65'(MSZ - 1);
        m_al = (a % 64'(n)) == 64'd0;
        m_lat = m_fault ? 1 : (m_al ? 2 : 1 + n);
        m_n = n;
        m_we = we;
        m_addr = a;
        m_wd = wd;
        d = 64'd0;
        if (!m_fault) begin
            for (int b = 0; b < n; b++) begin
                if (we) ref_mem[int'(a[31:0]) + b] = wd[8*b +: 8];
                else d[8*b +: 8] = ref_mem[int'(a[31:0]) + b];
            end
            if (!we && sg && d[8*n-1]) begin
                for (int b = n; b < 8; b++) d[8*b +: 8] = 8'hFF;
            end
        end
        m_rdata = (we || m_fault) ? 64'd0 : d;
    endtask

    task automatic issue(input logic we, input logic [1:0] sz,
                         input logic sg, input logic [63:0] a,
                         input logic [63:0] wd);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_we = we;
        req_size = sz;
        req_signed = sg;
        req_addr = a;
        req_wdata = wd;
        @(posedge clk);
        #1;
        in_txn = 1'b1;
        t_acc = cyc - 1;
        req_valid = 1'b0;
        req_we = ~we;
        req_size = ~sz;
        req_signed = ~sg;
        req_addr = ~a;
        req_wdata = ~wd;
    endtask

    task automatic xact(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int stall, input logic lit,
                        input logic [63:0] lit_rd, input logic lit_flt,
                        input int lit_lat);
        int waited;
        int obs_lat;
        logic [63:0] obs_rd;
        logic obs_flt;
        set_model(we, sz, sg, a, wd);
        issue(we, sz, sg, a, wd);
        waited = 0;
        obs_lat = -1;
        obs_rd = 64'd0;
        obs_flt = 1'b0;
        while (obs_lat < 0 && waited < 20) begin
            @(negedge clk);
            waited++;
            if (resp_valid) begin
                obs_lat = cyc - t_acc;
                obs_rd = resp_rdata;
                obs_flt = resp_fault;
            end
        end
        if (obs_lat < 0) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout actual=none required=resp_valid addr=%h", a);
            in_txn = 1'b0;
            #1 reset = 1'b1;
            #10 reset = 1'b0;
            return;
        end
        for (int s = 0; s < stall; s++) @(negedge clk);
        @(posedge clk);
        #1 resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        in_txn = 1'b0;
        if (lit) begin
            chk("lit_rdata", obs_rd, lit_rd);
            chk("lit_fault", 64'(obs_flt), 64'(lit_flt));
            chk("lit_latency", 64'(obs_lat), 64'(lit_lat));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        preload = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_signed = 1'b0;
        req_addr = 64'd0;
        req_wdata = 64'd0;
        resp_ready = 1'b0;
        for (int i = 0; i < MSZ; i++) ref_mem[i] = 8'(i * 7 + 3);
        #3;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_fault", 64'(resp_fault), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_widthsel", 64'(mem_widthsel), 64'd0);
        chk("rst_mem_writedata", mem_writedata, 64'd0);
        #9;
        reset = 1'b0;
        preload = 1'b0;

        xact(1, 2'b11, 0, 64'h10, 64'h1122334455667788, 0, 1, 64'd0, 0, 2);
        xact(0, 2'b11, 1, 64'h10, 64'h0, 0, 1, 64'h1122334455667788, 0, 2);
        xact(1, 2'b00, 0, 64'h20, 64'h80, 0, 1, 64'd0, 0, 2);
        xact(0, 2'b00, 1, 64'h20, 64'h0, 0, 1, 64'hFFFFFFFFFFFFFF80, 0, 2);
        xact(0, 2'b00, 0, 64'h20, 64'h0, 0, 1, 64'h80, 0, 2);
        xact(1, 2'b10, 0, 64'h101, 64'hAABBCCDD, 0, 1, 64'd0, 0, 5);
        xact(0, 2'b10, 0, 64'h101, 64'h0, 0, 1, 64'hAABBCCDD, 0, 5);
        check_image("basic");

        xact(0, 2'b11, 1, 64'h7FC, 64'h0, 0, 1, 64'd0, 1, 1);
        xact(0, 2'b00, 0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0, 1, 64'd0, 1, 1);
        xact(0, 2'b01, 1, 64'h102, 64'h0, 3, 1, 64'hFFFFFFFFFFFFBBCC, 0, 2);
        xact(0, 2'b11, 0, 64'h7F8, 64'h0, 0, 0, 64'd0, 0, 0);
        xact(0, 2'b10, 0, 64'h7FD, 64'h0, 0, 1, 64'd0, 1, 1);
        xact(1, 2'b01, 0, 64'h7FF, 64'h1234, 0, 1, 64'd0, 1, 1);
        xact(1, 2'b00, 0, 64'h7FF, 64'h5A, 0, 1, 64'd0, 0, 2);
        xact(1, 2'b10, 0, 64'hFFFFFFFFFFFFFFFE, 64'h99, 0, 1, 64'd0, 1, 1);
        xact(1, 2'b11, 0, 64'h333, 64'h0102030405060708, 1, 1, 64'd0, 0, 9);
        xact(0, 2'b10, 0, 64'h335, 64'h0, 0, 1, 64'h03040506, 0, 5);
        check_image("edges");

        // reset during the second byte of a split double store
        set_model(1, 2'b11, 0, 64'h201, 64'hF1E2D3C4B5A69788);
        for (int i = 0; i < 8; i++) ref_mem[32'h201 + i] = 8'(32'h201 * 7 + 3 + i * 7);
        ref_mem[32'h201] = 8'h88;
        issue(1, 2'b11, 0, 64'h201, 64'hF1E2D3C4B5A69788);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        in_txn = 1'b0;
        chk("rst_mid_mem_we", 64'(mem_we), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        chk("rst_mid_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mid_mem_addr", mem_addr, 64'd0);
        @(negedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        check_image("reset");
        xact(0, 2'b00, 0, 64'h201, 64'h0, 0, 1, 64'h88, 0, 2);
        xact(0, 2'b00, 0, 64'h202, 64'h0, 0, 1, 64'h11, 0, 2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter NKB, default 2, memory size in KiB; valid byte addresses are 0..NKB*1024-1.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request offered.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_we  input  1  1=store, 0=load.
REQ-007 SHALL have port req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 double.
REQ-008 SHALL have port req_signed  input  1  sign-extend load data when 1.
REQ-009 SHALL have port req_addr  input  64  byte address.
REQ-010 SHALL have port req_wdata  input  64  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  response available.
REQ-012 SHALL have port resp_ready  input  1  response consumed when high with resp_valid.
REQ-013 SHALL have port resp_rdata  output  64  load data, extended per req_signed; 0 for stores and faults.
REQ-014 SHALL have port resp_fault  output  1  access out of range; no memory access performed.
REQ-015 SHALL have port mem_addr  output  64  memory byte address.
REQ-016 SHALL have port mem_widthsel  output  3  byte enables: 000 byte, 001 half, 011 word, 111 double.
REQ-017 SHALL have port mem_writedata  output  64  memory write data.
REQ-018 SHALL have port mem_we  output  1  memory write strobe; memory writes enabled bytes on the clk edge.
REQ-019 SHALL have port mem_readdata  input  64  asynchronous memory read data, bytes above widthsel are zero.

Function
REQ-020 SHALL implement states IDLE, ACCESS, SPLIT, RESP; req_ready=1 only in IDLE.
REQ-021 SHALL in IDLE on req_valid latch all req_* fields; N=1<<req_size bytes.
REQ-022 SHALL flag fault when addr+N-1 > NKB*1024-1, computed without 64-bit wrap (addr near 2^64 is a fault); fault -> RESP, no mem_we ever.
REQ-023 SHALL go IDLE->ACCESS when addr mod N = 0, else IDLE->SPLIT with byte counter k=0.
REQ-024 SHALL in ACCESS drive mem_addr=addr, mem_widthsel per size, mem_writedata=wdata, mem_we=req_we for exactly one cycle, capture mem_readdata for loads, then go RESP.
REQ-025 SHALL in SPLIT drive, per cycle k: mem_addr=addr+k, mem_widthsel=000, mem_writedata[7:0]=wdata byte k (upper bits 0), mem_we=req_we; loads capture mem_readdata[7:0] into data byte k.
REQ-026 SHALL increment k each SPLIT cycle and go RESP after byte N-1 (N cycles in SPLIT).
REQ-027 SHALL in RESP hold resp_valid=1 with stable resp_rdata/resp_fault until resp_ready, then go IDLE; a new request is accepted no earlier than the cycle after the handshake.
REQ-028 SHALL zero-extend or sign-extend loaded data from bit 8N-1 to 64 bits.
REQ-029 SHALL latency, from accept edge T: aligned resp_valid at T+2; misaligned at T+1+N; fault at T+1.
REQ-030 SHALL drive mem_we=0, mem_widthsel=000, mem_addr=0, mem_writedata=0 in IDLE and RESP.
REQ-031 SHALL ignore req_* changes after acceptance.

Reset
REQ-032 SHALL on reset assertion immediately (asynchronously) enter IDLE: req_ready=1, resp_valid=0, resp_rdata=0, resp_fault=0, mem_we=0, all mem_* outputs 0, k=0.
REQ-033 SHALL abort any in-progress access on reset; bytes already written by SPLIT stay written, no response is produced.

Verification
REQ-034 Aligned double store addr=0x10 wdata=0x1122334455667788, then signed double load -> one mem_we cycle widthsel=111; load resp_rdata=0x1122334455667788 at T+2.
REQ-035 Byte 0x80 at addr 0x20, load size=00 signed=1 -> 0xFFFFFFFFFFFFFF80; signed=0 -> 0x80.
REQ-036 Misaligned word store addr=0x101 wdata=0xAABBCCDD -> 4 byte writes to 0x101..0x104 (DD,CC,BB,AA); word load from 0x101 returns 0xAABBCCDD, resp_valid at T+5.
REQ-037 NKB=2 double load addr=0x7FC -> resp_fault=1, resp_rdata=0, no mem_we, resp_valid at T+1; addr=0xFFFFFFFFFFFFFFFF byte -> fault.
REQ-038 resp_ready held 0 for 3 cycles -> resp_valid/resp_rdata stable, req_ready=0 throughout.
REQ-039 Reset asserted during SPLIT cycle k=1 of misaligned double store -> mem_we drops same cycle, state IDLE, only byte 0 written, no resp_valid.
